zjh_cmp_track: RTL and testbench

Sequential result tracker placed directly downstream of the 8-bit code-convert-and-compare stage. It consumes that stage's AEB/AGB/ALB flags. On each SAMPLE request it waits a programmable settle time, then latches the flags and checks that exactly one is set. It keeps saturating per-outcome counters and a run-length of identical consecutive outcomes, and signals completion with a one-cycle DONE pulse.

---
 rtl/zjh_cmp_track.sv | 150 +++++++++++++++
 tb/tb_zjh_cmp_track.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/zjh_cmp_track.sv
// zjh_cmp_track: measurement sequencer behind the code-convert-and-compare stage.
// Each accepted SAMPLE waits SETTLE cycles, then latches {AGB,AEB,ALB}, checks
// that the flags are one-hot and updates saturating outcome statistics.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no measurement in progress, waiting for SAMPLE
// WAIT  | settle counter running down, flags ignored
// LATCH | flags captured and statistics updated at the edge leaving here
module zjh_cmp_track #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CW     = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          AEB,
    input  logic          AGB,
    input  logic          ALB,
    input  logic          SAMPLE,
    input  logic          CLR,
    output logic          BUSY,
    output logic          DONE,
    output logic [2:0]    RES,
    output logic          ERR,
    output logic [CW-1:0] CNT_GT,
    output logic [CW-1:0] CNT_EQ,
    output logic [CW-1:0] CNT_LT,
    output logic [CW-1:0] RUN
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [3:0]    SETTLE_LD = 4'(SETTLE);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic       latch_en;

    logic [2:0] flags;
    logic       flags_valid;
    logic [2:0] prev_q;
    logic       hist_valid_q;

    assign flags       = {AGB, AEB, ALB};
    assign flags_valid = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign BUSY        = (state_q != ST_IDLE);

    // State and settle-counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            settle_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic; CLR overrides everything, including a completing LATCH.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SAMPLE) begin
                    if (SETTLE_LD == 4'd0) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d  = ST_WAIT;
                        settle_d = SETTLE_LD;
                    end
                end
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    settle_d = 4'd0;
                    state_d  = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch_en = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = 4'd0;
            end
        endcase
        if (CLR) begin
            state_d  = ST_IDLE;
            settle_d = 4'd0;
            latch_en = 1'b0;
        end
    end

    // Result capture, statistics and the DONE pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DONE         <= 1'b0;
            RES          <= 3'b000;
            ERR          <= 1'b0;
            CNT_GT       <= '0;
            CNT_EQ       <= '0;
            CNT_LT       <= '0;
            RUN          <= '0;
            prev_q       <= 3'b000;
            hist_valid_q <= 1'b0;
        end else if (CLR) begin
            DONE         <= 1'b0;
            RES          <= 3'b000;
            ERR          <= 1'b0;
            CNT_GT       <= '0;
            CNT_EQ       <= '0;
            CNT_LT       <= '0;
            RUN          <= '0;
            prev_q       <= 3'b000;
            hist_valid_q <= 1'b0;
        end else if (latch_en) begin
            DONE <= 1'b1;
            RES  <= flags;
            if (flags_valid) begin
                if (AGB && (CNT_GT != CNT_MAX)) CNT_GT <= CNT_GT + CNT_ONE;
                if (AEB && (CNT_EQ != CNT_MAX)) CNT_EQ <= CNT_EQ + CNT_ONE;
                if (ALB && (CNT_LT != CNT_MAX)) CNT_LT <= CNT_LT + CNT_ONE;
                if ((RUN != '0) && hist_valid_q && (prev_q == flags)) begin
                    if (RUN != CNT_MAX) RUN <= RUN + CNT_ONE;
                end else begin
                    RUN <= CNT_ONE;
                end
                prev_q       <= flags;
                hist_valid_q <= 1'b1;
            end else begin
                ERR          <= 1'b1;
                RUN          <= '0;
                hist_valid_q <= 1'b0;
            end
        end else begin
            DONE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zjh_cmp_track.sv
// Directed bench for zjh_cmp_track with SETTLE=2, CW=8.
module tb_zjh_cmp_track;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       AEB = 1'b0, AGB = 1'b0, ALB = 1'b0;
    logic       SAMPLE = 1'b0, CLR = 1'b0;
    logic       BUSY, DONE, ERR;
    logic [2:0] RES;
    logic [7:0] CNT_GT, CNT_EQ, CNT_LT, RUN;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    zjh_cmp_track #(.SETTLE(2), .CW(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .AEB(AEB), .AGB(AGB), .ALB(ALB),
        .SAMPLE(SAMPLE), .CLR(CLR), .BUSY(BUSY), .DONE(DONE), .RES(RES),
        .ERR(ERR), .CNT_GT(CNT_GT), .CNT_EQ(CNT_EQ), .CNT_LT(CNT_LT), .RUN(RUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [2:0] f);
        {AGB, AEB, ALB} = f;
    endtask

    // One measurement from a negedge; returns at the negedge where DONE is high.
    task automatic do_meas(input logic [2:0] f);
        logic got;
        got = 1'b0;
        set_flags(f);
        SAMPLE = 1'b1;
        @(negedge CLK);
        SAMPLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DONE) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic chk_stats(input string tag, input logic [7:0] gt, input logic [7:0] eq,
                             input logic [7:0] lt, input logic [7:0] run, input logic err);
        chk({tag, "_gt"}, {24'd0, CNT_GT}, {24'd0, gt});
        chk({tag, "_eq"}, {24'd0, CNT_EQ}, {24'd0, eq});
        chk({tag, "_lt"}, {24'd0, CNT_LT}, {24'd0, lt});
        chk({tag, "_run"}, {24'd0, RUN}, {24'd0, run});
        chk({tag, "_err"}, {31'd0, ERR}, {31'd0, err});
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (DONE) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int gap;
        logic found;

        // Reset and idle
        #23;
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_done", {31'd0, DONE}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("rst_res", {29'd0, RES}, 0);
        chk_stats("rst", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        no_done("idle_no_done", 20);
        chk("idle_busy", {31'd0, BUSY}, 0);

        // Single GT measurement with cycle-by-cycle timing
        set_flags(F_GT);
        SAMPLE = 1'b1;
        @(negedge CLK);                 // after E0
        SAMPLE = 1'b0;
        chk("e0_busy", {31'd0, BUSY}, 1);
        chk("e0_done", {31'd0, DONE}, 0);
        @(negedge CLK);                 // after E1
        chk("e1_busy", {31'd0, BUSY}, 1);
        chk("e1_done", {31'd0, DONE}, 0);
        @(negedge CLK);                 // after E2
        chk("e2_busy", {31'd0, BUSY}, 1);
        chk("e2_done", {31'd0, DONE}, 0);
        @(negedge CLK);                 // after E3
        chk("e3_busy", {31'd0, BUSY}, 0);
        chk("e3_done", {31'd0, DONE}, 1);
        chk("e3_res", {29'd0, RES}, {29'd0, F_GT});
        chk_stats("single", 8'd1, 8'd0, 8'd0, 8'd1, 1'b0);
        @(negedge CLK);
        chk("e4_done", {31'd0, DONE}, 0);

        // Run of EQ then switch to LT
        do_meas(F_EQ);
        chk("run_eq1", {24'd0, RUN}, 1);
        do_meas(F_EQ);
        chk("run_eq2", {24'd0, RUN}, 2);
        do_meas(F_EQ);
        chk("run_eq3", {24'd0, RUN}, 3);
        do_meas(F_LT);
        chk("res_lt", {29'd0, RES}, {29'd0, F_LT});
        chk_stats("switch", 8'd1, 8'd3, 8'd1, 8'd1, 1'b0);

        // SAMPLE held high: DONE every SETTLE+2 cycles
        @(negedge CLK);
        set_flags(F_LT);
        SAMPLE = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DONE) begin found = 1'b1; break; end
        end
        chk("held_first_done", {31'd0, found}, 1);
        gap = 0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            gap++;
            if (DONE) begin found = 1'b1; break; end
        end
        SAMPLE = 1'b0;
        chk("held_second_done", {31'd0, found}, 1);
        chk("held_spacing", gap, 4);
        chk_stats("held", 8'd1, 8'd3, 8'd3, 8'd3, 1'b0);
        no_done("held_stop", 6);
        chk("held_busy", {31'd0, BUSY}, 0);

        // Flag change during WAIT is ignored; only the latch-edge value counts
        set_flags(F_GT);
        SAMPLE = 1'b1;
        @(negedge CLK);
        SAMPLE = 1'b0;
        @(negedge CLK);
        set_flags(F_EQ);
        @(negedge CLK);
        @(negedge CLK);
        chk("late_done", {31'd0, DONE}, 1);
        chk("late_res", {29'd0, RES}, {29'd0, F_EQ});
        chk_stats("late", 8'd1, 8'd4, 8'd3, 8'd1, 1'b0);

        // Clear, then saturate with 300 GT outcomes
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_res", {29'd0, RES}, 0);
        chk_stats("clr", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 300; i++) do_meas(F_GT);
        chk_stats("sat", 8'd255, 8'd0, 8'd0, 8'd255, 1'b0);

        // Invalid flag patterns
        do_meas(3'b011);
        chk("inv_res", {29'd0, RES}, 3);
        chk_stats("inv", 8'd255, 8'd0, 8'd0, 8'd0, 1'b1);
        do_meas(F_GT);
        chk("inv_next_res", {29'd0, RES}, {29'd0, F_GT});
        chk_stats("inv_next", 8'd255, 8'd0, 8'd0, 8'd1, 1'b1);
        do_meas(3'b000);
        chk("zero_res", {29'd0, RES}, 0);
        chk_stats("zero", 8'd255, 8'd0, 8'd0, 8'd0, 1'b1);
        do_meas(F_LT);
        chk_stats("zero_next", 8'd255, 8'd0, 8'd1, 8'd1, 1'b1);

        // CLR during WAIT aborts without DONE
        @(negedge CLK);
        set_flags(F_EQ);
        SAMPLE = 1'b1;
        @(negedge CLK);
        SAMPLE = 1'b0;
        chk("abort_busy_pre", {31'd0, BUSY}, 1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("abort_busy", {31'd0, BUSY}, 0);
        chk("abort_done", {31'd0, DONE}, 0);
        chk("abort_res", {29'd0, RES}, 0);
        chk_stats("abort", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        no_done("abort_no_done", 6);

        // CLR and SAMPLE on the same edge: SAMPLE refused
        SAMPLE = 1'b1;
        CLR = 1'b1;
        @(negedge CLK);
        SAMPLE = 1'b0;
        CLR = 1'b0;
        chk("clr_sample_busy", {31'd0, BUSY}, 0);
        no_done("clr_sample_no_done", 6);
        chk_stats("clr_sample", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

        // Asynchronous reset during WAIT
        do_meas(F_GT);
        chk_stats("pre_rst", 8'd1, 8'd0, 8'd0, 8'd1, 1'b0);
        SAMPLE = 1'b1;
        @(negedge CLK);
        SAMPLE = 1'b0;
        chk("wait_busy", {31'd0, BUSY}, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_busy", {31'd0, BUSY}, 0);
        chk("arst_res", {29'd0, RES}, 0);
        chk_stats("arst", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        no_done("arst_no_done", 6);
        chk("arst_busy_after", {31'd0, BUSY}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
